// File: rtl/wb_msi_ram.sv
// Wishbone B4 slave RAM with classic and registered-feedback incrementing bursts,
// byte-lane writes, programmable wait states and error response outside DEPTH.
module wb_msi_ram #(
   parameter int    DW          = 32,
   parameter int    AW          = 32,
   parameter int    DEPTH       = 1024,
   parameter int    WAIT_CYCLES = 0,
   parameter string MEMFILE     = ""
) (
   input  logic            wb_clk_i,
   input  logic            wb_rst_i,
   input  logic [AW-1:0]   wb_adr_i,
   input  logic [DW-1:0]   wb_dat_i,
   input  logic [DW/8-1:0] wb_sel_i,
   input  logic            wb_we_i,
   input  logic            wb_cyc_i,
   input  logic            wb_stb_i,
   input  logic [2:0]      wb_cti_i,
   input  logic [1:0]      wb_bte_i,
   output logic [DW-1:0]   wb_dat_o,
   output logic            wb_ack_o,
   output logic            wb_err_o,
   output logic            wb_rty_o
);

   localparam int            WORDS = DEPTH / 4;
   localparam int            IW    = $clog2(WORDS);
   localparam logic [15:0]   WLAST = 16'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);
   localparam logic [AW-1:0] LIMIT = AW'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   logic [DW-1:0] mem [WORDS];
   state_t        state;
   logic [15:0]   wcnt;
   logic          burst;
   logic [AW-1:2] pred;
   logic [AW-1:0] nxt;
   logic          req, in_range, nxt_ok, mismatch, wr;
   logic [IW-1:0] idx, nidx;

   assign wb_rty_o = 1'b0;
   assign req      = wb_cyc_i & wb_stb_i;
   assign in_range = wb_adr_i < LIMIT;
   assign nxt_ok   = nxt < LIMIT;
   assign idx      = wb_adr_i[IW+1:2];
   assign nidx     = nxt[IW+1:2];
   // During a burst the master must follow our prediction; otherwise the beat is refused.
   assign mismatch = burst & (wb_adr_i[AW-1:2] != pred);
   assign wr       = (state == S_RESP) & req & wb_ack_o & ~mismatch & wb_we_i & in_range;

   always_comb begin
      nxt = {wb_adr_i[AW-1:2] + (AW-2)'(1), 2'b00};
      case (wb_bte_i)
         2'b01:   nxt = {wb_adr_i[AW-1:4], wb_adr_i[3:2] + 2'd1, 2'b00};
         2'b10:   nxt = {wb_adr_i[AW-1:5], wb_adr_i[4:2] + 3'd1, 2'b00};
         2'b11:   nxt = {wb_adr_i[AW-1:6], wb_adr_i[5:2] + 4'd1, 2'b00};
         default: ;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_i && wr)
         for (int b = 0; b < DW/8; b++)
            if (wb_sel_i[b]) mem[idx][8*b +: 8] <= wb_dat_i[8*b +: 8];
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state    <= S_IDLE;
         wcnt     <= '0;
         burst    <= 1'b0;
         pred     <= '0;
         wb_ack_o <= 1'b0;
         wb_err_o <= 1'b0;
         wb_dat_o <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (req) begin
                  if (WAIT_CYCLES > 0) begin
                     state <= S_WAIT;
                     wcnt  <= '0;
                  end else begin
                     state    <= S_RESP;
                     wb_ack_o <= in_range;
                     wb_err_o <= ~in_range;
                     wb_dat_o <= in_range ? mem[idx] : '0;
                  end
               end
            end
            S_WAIT: begin
               if (!req) begin
                  state <= S_IDLE;
               end else if (wcnt == WLAST) begin
                  state    <= S_RESP;
                  wb_ack_o <= in_range;
                  wb_err_o <= ~in_range;
                  wb_dat_o <= in_range ? mem[idx] : '0;
               end else begin
                  wcnt <= wcnt + 16'd1;
               end
            end
            S_RESP: begin
               // Burst continues only after an acked beat marked incrementing.
               if (req && !mismatch && wb_ack_o && wb_cti_i == 3'b010) begin
                  pred     <= nxt[AW-1:2];
                  burst    <= 1'b1;
                  wb_ack_o <= nxt_ok;
                  wb_err_o <= ~nxt_ok;
                  wb_dat_o <= nxt_ok ? mem[nidx] : '0;
               end else begin
                  state    <= S_IDLE;
                  burst    <= 1'b0;
                  wb_ack_o <= 1'b0;
                  wb_err_o <= 1'b0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
